// File: rtl/tdm_pkg.sv
// Shared TDM voice-mixer definitions: default geometry, FSM state encoding, clog2 helper.
// Latency: n/a (package).
// Backpressure: n/a (package).
package tdm_pkg;

  localparam int TDM_NUM_VOICES = 8;
  localparam int TDM_CHANBITS   = 3;
  localparam int TDM_D_W        = 16;

  typedef enum logic {
    SYNC  = 1'b0,
    ACCUM = 1'b1
  } tdm_state_t;

  // Bounded loop so the same function serves elaboration and combinational use.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/tdm_mix_normaliser.sv
// Frame-sum normaliser: fixed >>CHANBITS, or >>clog2(count) with TDM_MIX_DYN_NORM_EN.
// Latency: combinational.
// Backpressure: none; pure function of (sum, count).
module tdm_mix_normaliser
  import tdm_pkg::*;
#(
  parameter int CHANBITS = TDM_CHANBITS,
  parameter int D_W      = TDM_D_W,
  parameter int ACC_W    = D_W + CHANBITS
) (
  input  logic [ACC_W-1:0]  sum,
  input  logic [CHANBITS:0] count,
  output logic [D_W-1:0]    mix
);

`ifdef TDM_MIX_DYN_NORM_EN
  int shift_amt;

  assign shift_amt = clog2(int'(count));
  // count <= 2^shift_amt keeps the shifted sum within D_W bits.
  assign mix = (count == '0) ? '0 : D_W'(sum >> shift_amt);
`else
  logic unused_count;

  assign unused_count = ^count;
  assign mix          = D_W'(sum >> CHANBITS);
`endif

endmodule

// File: rtl/tdm_voice_mixer.sv
// TDM voice mixer: sums one sample per slot over a frame, emits normalised mix (TDM_MIX_DYN_NORM_EN selects dynamic shift).
// Latency: 1 cycle from last slot to mix_valid; out-of-order slot pulses frame_err next cycle.
// Backpressure: none; slots are accepted whenever dsp_enable is high.
module tdm_voice_mixer
  import tdm_pkg::*;
#(
  parameter int NUM_VOICES = TDM_NUM_VOICES,
  parameter int CHANBITS   = TDM_CHANBITS,
  parameter int D_W        = TDM_D_W,
  parameter int ACC_W      = D_W + CHANBITS
) (
  input  logic                dsp_clk,
  input  logic                dsp_rst_n,
  input  logic                dsp_enable,
  input  logic [CHANBITS-1:0] chan_in,
  input  logic                chan_enabled_in,
  input  logic [D_W-1:0]      data_in,
  output logic [D_W-1:0]      mix_out,
  output logic                mix_valid,
  output logic [CHANBITS:0]   active_count,
  output logic                frame_err
);

  localparam logic [CHANBITS-1:0] LAST_CHAN = CHANBITS'(NUM_VOICES - 1);

  tdm_state_t          state;
  logic [ACC_W-1:0]    acc;
  logic [CHANBITS:0]   count;
  logic [CHANBITS-1:0] expected;

  logic [ACC_W-1:0]    sample_ext;
  logic [CHANBITS:0]   en_ext;
  logic [ACC_W-1:0]    sum_next;
  logic [CHANBITS:0]   cnt_next;
  logic [D_W-1:0]      mix_val;

  assign sample_ext = chan_enabled_in ? ACC_W'(data_in) : '0;
  assign en_ext     = {{CHANBITS{1'b0}}, chan_enabled_in};
  assign sum_next   = acc + sample_ext;
  assign cnt_next   = count + en_ext;

  // Normalised from the in-flight sum so the mix registers on the last slot itself.
  tdm_mix_normaliser #(
    .CHANBITS (CHANBITS),
    .D_W      (D_W),
    .ACC_W    (ACC_W)
  ) u_norm (
    .sum   (sum_next),
    .count (cnt_next),
    .mix   (mix_val)
  );

  always_ff @(posedge dsp_clk or negedge dsp_rst_n) begin
    if (!dsp_rst_n) begin
      state        <= SYNC;
      acc          <= '0;
      count        <= '0;
      expected     <= '0;
      mix_out      <= '0;
      mix_valid    <= 1'b0;
      active_count <= '0;
      frame_err    <= 1'b0;
    end else begin
      mix_valid <= 1'b0;
      frame_err <= 1'b0;
      if (dsp_enable) begin
        case (state)
          SYNC: begin
            if (chan_in == '0) begin
              acc      <= sample_ext;
              count    <= en_ext;
              expected <= CHANBITS'(1);
              state    <= ACCUM;
            end
          end
          ACCUM: begin
            if (chan_in == expected) begin
              if (chan_in == LAST_CHAN) begin
                mix_out      <= mix_val;
                mix_valid    <= 1'b1;
                active_count <= cnt_next;
                acc          <= '0;
                count        <= '0;
                state        <= SYNC;
              end else begin
                acc      <= sum_next;
                count    <= cnt_next;
                expected <= expected + CHANBITS'(1);
              end
            end else begin
              frame_err <= 1'b1;
              if (chan_in == '0) begin
                acc      <= sample_ext;
                count    <= en_ext;
                expected <= CHANBITS'(1);
              end else begin
                acc   <= '0;
                count <= '0;
                state <= SYNC;
              end
            end
          end
          default: state <= SYNC;
        endcase
      end
    end
  end

endmodule

// File: doc/tdm_voice_mixer.md
Name: tdm_voice_mixer

Overview:
- Parametrised successor to the fixed 4-voice terminal summer at the end of the TDM sample pipeline.
- Accumulates one sample per voice slot over a TDM frame of NUM_VOICES slots and counts only enabled voices.
- Normalises the frame sum, then emits one mixed sample per frame with a valid strobe.
- Checks slot ordering: on a sequence error it drops the frame and resynchronises.

Parameters:
- NUM_VOICES, 8: slots per TDM frame; must be a power of two, at least 2.
- CHANBITS, 3: voice index width; equals log2(NUM_VOICES).
- D_W, 16: sample width; unsigned fix15_u16.
- ACC_W, D_W+CHANBITS: accumulator width; guarantees no overflow.

Ports:
- dsp_clk  in  1  DSP clock; all logic on rising edge.
- dsp_rst_n  in  1  asynchronous active-low reset.
- dsp_enable  in  1  slot strobe; inputs are sampled only when high.
- chan_in  in  CHANBITS  voice index of the current slot.
- chan_enabled_in  in  1  voice is active; a disabled slot contributes 0.
- data_in  in  D_W  voice sample.
- mix_out  out  D_W  normalised frame mix; held between frames.
- mix_valid  out  1  one-cycle pulse when mix_out updates.
- active_count  out  CHANBITS+1  enabled voices in the last completed frame.
- frame_err  out  1  one-cycle pulse on a slot sequence violation.

Behaviour:
- Reset (async assert, sync release): mix_out=0, mix_valid=0, active_count=0, frame_err=0, accumulator=0, internal count=0, state=SYNC.
- Accepted slot: a cycle with dsp_enable=1. Cycles with dsp_enable=0 change nothing; mix_valid and frame_err still deassert.
- State SYNC: wait for an accepted slot with chan_in=0.
  - Load accumulator with data_in if enabled, else 0.
  - Load count with chan_enabled_in; expected=1; go to ACCUM.
  - Accepted slots with chan_in≠0 are ignored, with no frame_err.
- State ACCUM, accepted slot with chan_in==expected:
  - accumulator += enabled ? data_in : 0; count += chan_enabled_in; expected++.
- State ACCUM, accepted slot with chan_in≠expected:
  - Pulse frame_err next cycle and discard the partial frame.
  - If chan_in==0, restart the frame in the same cycle (same load as SYNC) and stay in ACCUM.
  - Otherwise go to SYNC.
- Frame completion: accepted slot with chan_in==NUM_VOICES-1 and matching expected.
  - Next cycle: mix_out = (final sum) >> CHANBITS, mix_valid=1, active_count = final count.
  - State returns to SYNC. Latency is 1 cycle from the last slot to mix_valid.
  - A chan_in=0 slot in the cycle right after completion is accepted as a new frame start; this gives back-to-back frames.
- Width rules:
  - Unsigned arithmetic only; zero-extend data_in to ACC_W.
  - Maximum sum is NUM_VOICES*(2^D_W-1), which fits ACC_W bits.
  - The shifted result fits D_W bits; no saturation needed.
- A frame with all voices disabled outputs mix_out=0 with mix_valid=1.
- Reset mid-frame discards the partial sum; no mix_valid is produced for it.

Optional Feature:
- Macro: TDM_MIX_DYN_NORM_EN.
- Defined: the shift is clog2(final count), not CHANBITS.
  - count 0 gives mix_out=0; count 1 gives shift 0; 2 gives 1; 3-4 gives 2; 5-8 gives 3; same pattern for larger NUM_VOICES.
  - The result always fits D_W bits, because count ≤ 2^shift.
  - Latency is unchanged.
- Undefined: fixed shift of CHANBITS; no count-to-shift logic is synthesised.

Decomposition:
- Shared package tdm_pkg:
  - NUM_VOICES, CHANBITS and D_W defaults.
  - State encoding: SYNC=0, ACCUM=1.
  - clog2 constant function.
- One sub-module: tdm_mix_normaliser. Combinational shift select taking (sum, count) and giving mix value; it holds the TDM_MIX_DYN_NORM_EN branch.

Test Plan:
1. Reset, then one frame with all 8 voices enabled, each data=0x1000 -> one cycle after slot 7: mix_out=0x1000, mix_valid=1 (one cycle), active_count=8.
2. Frame with voices 0-7 = 0xFFFF, all enabled -> mix_out=0xFFFF; no overflow wrap.
3. Only voices 1 and 5 enabled at 0x8000, others carry 0xFFFF -> fixed mode: mix_out=0x2000, active_count=2. TDM_MIX_DYN_NORM_EN: mix_out=0x8000.
4. Sequence 0,1,2,4 -> frame_err pulse after slot 4, no mix_valid. Following 0..7 frame at 0x0800 -> mix_out=0x0800.
5. Slots 0..7 with dsp_enable toggling 1,0 on alternate cycles -> same result as the contiguous frame; mix_valid one cycle after the last accepted slot.
6. Assert dsp_rst_n=0 after slot 3, release, send full frame of 0x0400 -> outputs 0 during reset, then mix_out=0x0400 with a single mix_valid.
